// File: rtl/ex_operand_stage.sv
// ID->EX pipeline register with operand forwarding and operand-mux selection.
// Optional feature: define EX_OPERAND_FORWARD_EN to enable MEM/WB forwarding.
module ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_rdata1,
  input  logic [XLEN-1:0] id_rdata2,
  input  logic [RW-1:0]   id_rs1,
  input  logic [RW-1:0]   id_rs2,
  input  logic [RW-1:0]   id_rd,
  input  logic [3:0]      id_alu_control,
  input  logic            id_src_a_pc,
  input  logic            id_src_b_imm,
  input  logic            id_reg_write,
  input  logic            stall,
  input  logic            flush,
  input  logic            mem_reg_write,
  input  logic [RW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_reg_write,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] src_a,
  output logic [XLEN-1:0] src_b,
  output logic [3:0]      alu_control,
  output logic            ex_valid,
  output logic [RW-1:0]   ex_rd,
  output logic            ex_reg_write,
  output logic [XLEN-1:0] ex_store_data
);

  logic            validQ;
  logic            regWriteQ;
  logic [3:0]      aluQ;
  logic [RW-1:0]   rdQ;
  logic [RW-1:0]   rs1Q;
  logic [RW-1:0]   rs2Q;
  logic [XLEN-1:0] pcQ;
  logic [XLEN-1:0] immQ;
  logic [XLEN-1:0] rdata1Q;
  logic [XLEN-1:0] rdata2Q;
  logic            srcAPcQ;
  logic            srcBImmQ;
  logic [XLEN-1:0] fwdA;
  logic [XLEN-1:0] fwdB;

`ifdef EX_OPERAND_FORWARD_EN
  logic memHitA;
  logic memHitB;
  logic wbHitA;
  logic wbHitB;

  // Index 0 is hardwired to zero, so it never matches a producer.
  assign memHitA = mem_reg_write && (mem_rd == rs1Q) && (rs1Q != '0);
  assign memHitB = mem_reg_write && (mem_rd == rs2Q) && (rs2Q != '0);
  assign wbHitA  = wb_reg_write  && (wb_rd  == rs1Q) && (rs1Q != '0);
  assign wbHitB  = wb_reg_write  && (wb_rd  == rs2Q) && (rs2Q != '0);

  // MEM holds the younger result, so it takes priority over WB.
  always_comb begin
    fwdA = rdata1Q;
    fwdB = rdata2Q;
    if (memHitA)     fwdA = mem_result;
    else if (wbHitA) fwdA = wb_result;
    if (memHitB)     fwdB = mem_result;
    else if (wbHitB) fwdB = wb_result;
  end
`else
  logic unusedFwd;

  assign fwdA = rdata1Q;
  assign fwdB = rdata2Q;
  assign unusedFwd = ^{mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result};
`endif

  // Flush beats stall; while held, a retiring WB value is folded into the
  // latched operands so it is still visible once the stall lifts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      validQ    <= 1'b0;
      regWriteQ <= 1'b0;
      aluQ      <= 4'b0000;
      rdQ       <= '0;
      rs1Q      <= '0;
      rs2Q      <= '0;
      pcQ       <= '0;
      immQ      <= '0;
      rdata1Q   <= '0;
      rdata2Q   <= '0;
      srcAPcQ   <= 1'b0;
      srcBImmQ  <= 1'b0;
    end else if (!stall) begin
      validQ    <= id_valid;
      regWriteQ <= id_reg_write;
      aluQ      <= id_alu_control;
      rdQ       <= id_rd;
      rs1Q      <= id_rs1;
      rs2Q      <= id_rs2;
      pcQ       <= id_pc;
      immQ      <= id_imm;
      rdata1Q   <= id_rdata1;
      rdata2Q   <= id_rdata2;
      srcAPcQ   <= id_src_a_pc;
      srcBImmQ  <= id_src_b_imm;
    end
`ifdef EX_OPERAND_FORWARD_EN
    else begin
      if (wbHitA) rdata1Q <= wb_result;
      if (wbHitB) rdata2Q <= wb_result;
    end
`endif
  end

  assign src_a         = srcAPcQ  ? pcQ  : fwdA;
  assign src_b         = srcBImmQ ? immQ : fwdB;
  assign ex_store_data = fwdB;
  assign alu_control   = aluQ;
  assign ex_valid      = validQ;
  assign ex_rd         = rdQ;
  assign ex_reg_write  = regWriteQ & validQ;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed scoreboard bench for ex_operand_stage; tracks EX_OPERAND_FORWARD_EN
// so expectations follow whichever build is compiled.
module tb_ex_operand_stage;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_pc, id_imm, id_rdata1, id_rdata2;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_control;
  logic        id_src_a_pc, id_src_b_imm, id_reg_write;
  logic        stall, flush;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic [31:0] src_a, src_b, ex_store_data;
  logic [3:0]  alu_control;
  logic        ex_valid, ex_reg_write;
  logic [4:0]  ex_rd;

  ex_operand_stage #(.XLEN(32), .RW(5)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_alu_control(id_alu_control), .id_src_a_pc(id_src_a_pc),
    .id_src_b_imm(id_src_b_imm), .id_reg_write(id_reg_write), .stall(stall),
    .flush(flush), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_result(mem_result), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_result(wb_result), .src_a(src_a), .src_b(src_b), .alu_control(alu_control),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_store_data(ex_store_data)
  );

  typedef struct {
    string       tag;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] store;
    logic [3:0]  alu;
    logic        valid;
    logic        rw;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  // Reference copy of the stage contents.
  logic        mValid, mRw, mAPc, mBImm;
  logic [3:0]  mAlu;
  logic [4:0]  mRd, mRs1, mRs2;
  logic [31:0] mPc, mImm, mR1, mR2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] fwdModel(logic [4:0] rs, logic [31:0] rdata);
`ifdef EX_OPERAND_FORWARD_EN
    if (mem_reg_write && mem_rd == rs && rs != 5'd0) return mem_result;
    if (wb_reg_write && wb_rd == rs && rs != 5'd0) return wb_result;
`endif
    return rdata;
  endfunction

  task automatic clearModel();
    mValid = 0; mRw = 0; mAPc = 0; mBImm = 0; mAlu = 4'b0000; mRd = 0;
    mRs1 = 0; mRs2 = 0; mPc = 0; mImm = 0; mR1 = 0; mR2 = 0;
  endtask

  task automatic modelEdge();
    if (reset || flush) clearModel();
    else if (!stall) begin
      mValid = id_valid; mRw = id_reg_write; mAPc = id_src_a_pc; mBImm = id_src_b_imm;
      mAlu = id_alu_control; mRd = id_rd; mRs1 = id_rs1; mRs2 = id_rs2;
      mPc = id_pc; mImm = id_imm; mR1 = id_rdata1; mR2 = id_rdata2;
    end
`ifdef EX_OPERAND_FORWARD_EN
    else begin
      if (wb_reg_write && wb_rd == mRs1 && mRs1 != 5'd0) mR1 = wb_result;
      if (wb_reg_write && wb_rd == mRs2 && mRs2 != 5'd0) mR2 = wb_result;
    end
`endif
  endtask

  task automatic pushExpected(string tag);
    exp_t e;
    e.tag   = tag;
    e.a     = mAPc ? mPc : fwdModel(mRs1, mR1);
    e.b     = mBImm ? mImm : fwdModel(mRs2, mR2);
    e.store = fwdModel(mRs2, mR2);
    e.alu   = mAlu;
    e.valid = mValid;
    e.rw    = mRw & mValid;
    e.rd    = mRd;
    sb.push_back(e);
  endtask

  task automatic cmp(string tag, string field, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s.%s observed=0x%0h expected=0x%0h", tag, field, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = sb.pop_front();
    cmp(e.tag, "src_a", src_a, e.a);
    cmp(e.tag, "src_b", src_b, e.b);
    cmp(e.tag, "store", ex_store_data, e.store);
    cmp(e.tag, "alu", {28'd0, alu_control}, {28'd0, e.alu});
    cmp(e.tag, "valid", {31'd0, ex_valid}, {31'd0, e.valid});
    cmp(e.tag, "reg_write", {31'd0, ex_reg_write}, {31'd0, e.rw});
    cmp(e.tag, "rd", {27'd0, ex_rd}, {27'd0, e.rd});
  endtask

  // One clock: predict the post-edge stage, clock it, then compare.
  task automatic applyStimulus(string tag);
    modelEdge();
    pushExpected(tag);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic checkNow(string tag);
    pushExpected(tag);
    #1;
    checkOutput();
  endtask

  task automatic setId(logic v, logic [31:0] pc, logic [31:0] imm, logic [31:0] r1,
                       logic [31:0] r2, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                       logic [3:0] alu, logic aPc, logic bImm, logic rw);
    id_valid = v; id_pc = pc; id_imm = imm; id_rdata1 = r1; id_rdata2 = r2;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_alu_control = alu;
    id_src_a_pc = aPc; id_src_b_imm = bImm; id_reg_write = rw;
  endtask

  task automatic setFwd(logic mw, logic [4:0] mrd, logic [31:0] mres,
                        logic ww, logic [4:0] wrd, logic [31:0] wres);
    mem_reg_write = mw; mem_rd = mrd; mem_result = mres;
    wb_reg_write = ww; wb_rd = wrd; wb_result = wres;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    setFwd(0, 0, 0, 0, 0, 0);
    setId(1, 32'h40, 32'h8, 32'hAA, 32'hBB, 5'd1, 5'd2, 5'd3, 4'b0110, 0, 0, 1);
    clearModel();
    #1;
    checkNow("reset_during");
    applyStimulus("reset_edge1");
    applyStimulus("reset_edge2");
    reset = 1'b0;
    checkNow("reset_released");

    setId(1, 32'h100, 32'h0, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 4'b0000, 0, 0, 1);
    applyStimulus("basic");

    setId(1, 32'h104, 32'h0, 32'h33, 32'h0, 5'd3, 5'd0, 5'd8, 4'b0001, 0, 0, 1);
    setFwd(1, 5'd3, 32'h10, 1, 5'd3, 32'h20);
    applyStimulus("fwd_mem_wins");
    mem_reg_write = 1'b0;
    checkNow("fwd_wb_only");

    setId(1, 32'h108, 32'h0, 32'h44, 32'h0, 5'd0, 5'd0, 5'd9, 4'b0010, 0, 0, 1);
    setFwd(1, 5'd0, 32'h10, 1, 5'd0, 32'h20);
    applyStimulus("fwd_rs_zero");

    setId(1, 32'h10C, 32'h0, 32'h1, 32'h66, 5'd6, 5'd4, 5'd10, 4'b0011, 0, 0, 1);
    setFwd(1, 5'd4, 32'hA0, 1, 5'd4, 32'hB0);
    applyStimulus("fwd_b_mem");

    setFwd(0, 0, 0, 0, 0, 0);
    setId(1, 32'h110, 32'h0, 32'h99, 32'h11, 5'd5, 5'd4, 5'd6, 4'b0100, 0, 0, 0);
    applyStimulus("stall_load");
    stall = 1'b1;
    setId(1, 32'h200, 32'h4, 32'hDEAD, 32'hBEEF, 5'd7, 5'd7, 5'd7, 4'b1111, 1, 1, 1);
    setFwd(0, 0, 0, 1, 5'd4, 32'h55);
    applyStimulus("stall_wb_capture");
    setFwd(0, 0, 0, 1, 5'd9, 32'h77);
    applyStimulus("stall_wb_changed");
    setFwd(0, 0, 0, 0, 0, 0);
    checkNow("stall_held");
    stall = 1'b0;
    applyStimulus("stall_release");

    stall = 1'b1; flush = 1'b1;
    applyStimulus("flush_over_stall");
    stall = 1'b0; flush = 1'b0;
    setId(1, 32'h300, 32'hFFFF_FFFC, 32'h10, 32'h1234, 5'd2, 5'd7, 5'd11, 4'b1010, 1, 1, 1);
    applyStimulus("imm_store");

    setId(0, 32'h304, 32'h0, 32'h1, 32'h2, 5'd1, 5'd2, 5'd12, 4'b0111, 0, 0, 1);
    applyStimulus("invalid_no_write");

    setId(1, 32'h400, 32'h0, 32'h5, 32'h6, 5'd1, 5'd2, 5'd12, 4'b0101, 0, 0, 1);
    applyStimulus("pre_reset_load");
    stall = 1'b1;
    #2;
    reset = 1'b1;
    clearModel();
    checkNow("reset_mid_stall");
    applyStimulus("reset_mid_stall_edge");
    reset = 1'b0; stall = 1'b0;
    checkNow("post_reset");
    applyStimulus("post_reset_capture");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width.
REQ-002 SHALL have parameter RW, default 5: register-index width.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports id_valid in 1, id_pc in XLEN, id_imm in XLEN, id_rdata1 in XLEN, id_rdata2 in XLEN: decoded instruction from ID.
REQ-006 SHALL have ports id_rs1, id_rs2, id_rd  in  RW each: source/destination indices.
REQ-007 SHALL have ports id_alu_control in 4 (ALU opcode), id_src_a_pc in 1 (1 = A from PC), id_src_b_imm in 1 (1 = B from imm), id_reg_write in 1.
REQ-008 SHALL have ports stall in 1 (hold stage), flush in 1 (insert bubble).
REQ-009 SHALL have ports mem_reg_write in 1, mem_rd in RW, mem_result in XLEN: EX/MEM forward source.
REQ-010 SHALL have ports wb_reg_write in 1, wb_rd in RW, wb_result in XLEN: MEM/WB forward source.
REQ-011 SHALL have outputs src_a out XLEN, src_b out XLEN, alu_control out 4: ALU operands/opcode.
REQ-012 SHALL have outputs ex_valid out 1, ex_rd out RW, ex_reg_write out 1, ex_store_data out XLEN.

Function
REQ-013 SHALL register all id_* inputs on rising clk when stall=0 and flush=0 (one-cycle ID->EX latency).
REQ-014 SHALL, when flush=1 at clk edge, load a bubble: ex_valid=0, ex_reg_write=0, alu_control=4'b0000, rd/rs/data/imm/pc fields 0; flush SHALL override stall.
REQ-015 SHALL, when stall=1 and flush=0, hold all stage registers except as in REQ-019.
REQ-016 SHALL compute forwarded operand fa combinationally from latched rs1: if mem_reg_write and mem_rd==rs1 and rs1!=0 -> mem_result; else if wb_reg_write and wb_rd==rs1 and rs1!=0 -> wb_result; else latched rdata1. fb identical on rs2/rdata2.
REQ-017 SHALL drive src_a = src_a_pc ? pc : fa; src_b = src_b_imm ? imm : fb; ex_store_data = fb regardless of src_b_imm.
REQ-018 SHALL drive alu_control, ex_rd, ex_reg_write, ex_valid directly from stage registers (no combinational path from id_*).
REQ-019 SHALL, during stall, overwrite latched rdata1 (rdata2) with wb_result at clk edge when wb_reg_write=1, wb_rd==rs1 (rs2), index!=0, so a retiring value is not lost while held.
REQ-020 SHALL, when MEM and WB both match the same index, select MEM (youngest wins).
REQ-021 SHALL never forward to index 0; rs=0 operand SHALL read latched rdata (0 from regfile).
REQ-022 SHALL produce ex_valid=0 outputs as a bubble: ex_reg_write forced 0 whenever ex_valid=0.

Reset
REQ-023 SHALL, on reset assertion, immediately clear all stage registers: ex_valid=0, ex_reg_write=0, alu_control=4'b0000, ex_rd=0, pc/imm/rdata=0, so src_a=src_b=ex_store_data=0.
REQ-024 SHALL release reset synchronously to clk; first capture on first edge after deassertion with stall=0.
REQ-025 SHALL, on reset mid-stall or mid-flush, discard held instruction; no state survives.

Configuration
REQ-026 SHALL support macro EX_OPERAND_FORWARD_EN: defined -> REQ-016/019/020 forwarding active; undefined -> fa/fb = latched rdata1/rdata2, mem_*/wb_* inputs ignored, REQ-019 write-back capture removed (hazards resolved by upstream stall).

Verification
REQ-027 SHALL cover: reset with id_valid=1 -> all outputs 0, alu_control=0000 during and one cycle after reset.
REQ-028 SHALL cover: rdata1=5, rdata2=7, alu_control=0000, no hazard -> next cycle src_a=5, src_b=7, ex_valid=1.
REQ-029 SHALL cover: rs1=3, mem_rd=3 mem_result=0x10, wb_rd=3 wb_result=0x20 (both write) -> src_a=0x10; with mem_reg_write=0 -> 0x20; rs1=0 with mem_rd=0 -> src_a=rdata1.
REQ-030 SHALL cover: stall=1 two cycles, wb_rd=rs2=4 wb_result=0x55 in first stall cycle, then WB changes -> after stall, ex_store_data=0x55.
REQ-031 SHALL cover: flush=1 with stall=1 -> ex_valid=0, ex_reg_write=0 next cycle; src_b_imm=1 imm=0xFFFFFFFC -> src_b=0xFFFFFFFC, ex_store_data=fb.
REQ-032 SHALL cover: macro undefined, mem_rd=rs1 match -> src_a=latched rdata1.
